// File: rtl/tag_ram_flush_arbiter.sv
// Front end of the L1.5 tag RAM: arbitrates refill writes and lookups, and runs the flush sweep.
// Optional macro TAG_FLUSH_ON_RESET_EN: when defined, a full flush sweep starts automatically after reset.
module tag_ram_flush_arbiter #(
   parameter int data_width = 7,
   parameter int addr_width = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush_req_i,
   output logic                  flush_ack_o,
   output logic                  busy_o,
   input  logic                  lookup_req_i,
   input  logic [addr_width-1:0] lookup_addr_i,
   output logic                  lookup_gnt_o,
   output logic                  lookup_rvalid_o,
   input  logic                  refill_req_i,
   input  logic [addr_width-1:0] refill_addr_i,
   input  logic [data_width-1:0] refill_wdata_i,
   output logic                  refill_gnt_o,
   output logic                  tag_req_o,
   output logic                  tag_write_o,
   output logic [addr_width-1:0] tag_addr_o,
   output logic [data_width-1:0] tag_wdata_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FLUSH = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam logic [addr_width-1:0] CNT_ZERO = {addr_width{1'b0}};
   localparam logic [addr_width-1:0] CNT_ONE  = {{(addr_width-1){1'b0}}, 1'b1};
   localparam logic [addr_width-1:0] CNT_LAST = {addr_width{1'b1}};
   localparam logic [data_width-1:0] TAG_ZERO = {data_width{1'b0}};

`ifdef TAG_FLUSH_ON_RESET_EN
   localparam logic PENDING_RST = 1'b1;
`else
   localparam logic PENDING_RST = 1'b0;
`endif

   state_e                state_q, state_d;
   logic [addr_width-1:0] cnt_q, cnt_d;
   logic                  pending_flush_q, pending_flush_d;
   logic                  rvalid_q, rvalid_d;
   logic                  ack_q, ack_d;

   // Next-state, arbitration and tag RAM pin decode.
   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      pending_flush_d = pending_flush_q;
      ack_d           = 1'b0;
      lookup_gnt_o    = 1'b0;
      refill_gnt_o    = 1'b0;
      tag_req_o       = 1'b0;
      tag_write_o     = 1'b0;
      tag_addr_o      = CNT_ZERO;
      tag_wdata_o     = TAG_ZERO;

      case (state_q)
         IDLE: begin
            if (pending_flush_q || flush_req_i) begin
               state_d         = FLUSH;
               cnt_d           = CNT_ZERO;
               pending_flush_d = 1'b0;
            end else if (refill_req_i) begin
               refill_gnt_o = 1'b1;
               tag_req_o    = 1'b1;
               tag_write_o  = 1'b1;
               tag_addr_o   = refill_addr_i;
               tag_wdata_o  = refill_wdata_i;
            end else if (lookup_req_i) begin
               lookup_gnt_o = 1'b1;
               tag_req_o    = 1'b1;
               tag_addr_o   = lookup_addr_i;
            end else begin
               state_d = IDLE;
            end
         end
         FLUSH: begin
            tag_req_o   = 1'b1;
            tag_write_o = 1'b1;
            tag_addr_o  = cnt_q;
            if (cnt_q == CNT_LAST) begin
               cnt_d   = CNT_ZERO;
               state_d = DONE;
               ack_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
            // A request arriving mid-sweep is remembered and served by a fresh sweep.
            if (flush_req_i) begin
               pending_flush_d = 1'b1;
            end else begin
               pending_flush_d = pending_flush_q;
            end
         end
         DONE: begin
            state_d = IDLE;
            if (flush_req_i) begin
               pending_flush_d = 1'b1;
            end else begin
               pending_flush_d = pending_flush_q;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = CNT_ZERO;
         end
      endcase

      rvalid_d = lookup_gnt_o;
   end

   // State, sweep counter and registered strobes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         cnt_q           <= CNT_ZERO;
         pending_flush_q <= PENDING_RST;
         rvalid_q        <= 1'b0;
         ack_q           <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         pending_flush_q <= pending_flush_d;
         rvalid_q        <= rvalid_d;
         ack_q           <= ack_d;
      end
   end

   assign lookup_rvalid_o = rvalid_q;
   assign flush_ack_o     = ack_q;
   assign busy_o          = pending_flush_q | (state_q != IDLE);

endmodule

// File: tb/tb_tag_ram_flush_arbiter.sv
// Scoreboard bench for tag_ram_flush_arbiter: stimulus queues expected RAM accesses,
// read data, flush acks and status snapshots; a negedge monitor pops and compares them.
module tb_tag_ram_flush_arbiter;
   localparam int AW = 6;
   localparam int DW = 7;
   localparam int N  = 1 << AW;
`ifdef TAG_FLUSH_ON_RESET_EN
   localparam logic BUSY_RST = 1'b1;
`else
   localparam logic BUSY_RST = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush_req_i, flush_ack_o, busy_o;
   logic          lookup_req_i, lookup_gnt_o, lookup_rvalid_o;
   logic [AW-1:0] lookup_addr_i, refill_addr_i, tag_addr_o;
   logic          refill_req_i, refill_gnt_o;
   logic [DW-1:0] refill_wdata_i, tag_wdata_o;
   logic          tag_req_o, tag_write_o;

   always #5 clk = ~clk;

   tag_ram_flush_arbiter #(.data_width(DW), .addr_width(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .flush_req_i(flush_req_i), .flush_ack_o(flush_ack_o), .busy_o(busy_o),
      .lookup_req_i(lookup_req_i), .lookup_addr_i(lookup_addr_i),
      .lookup_gnt_o(lookup_gnt_o), .lookup_rvalid_o(lookup_rvalid_o),
      .refill_req_i(refill_req_i), .refill_addr_i(refill_addr_i),
      .refill_wdata_i(refill_wdata_i), .refill_gnt_o(refill_gnt_o),
      .tag_req_o(tag_req_o), .tag_write_o(tag_write_o),
      .tag_addr_o(tag_addr_o), .tag_wdata_o(tag_wdata_o)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural single-port tag RAM with one-cycle read latency.
   logic [DW-1:0] mem [N];
   logic [DW-1:0] rdata;
   always @(posedge clk) begin
      if (tag_req_o) begin
         if (tag_write_o) mem[tag_addr_o] <= tag_wdata_o;
         else             rdata <= mem[tag_addr_o];
      end
   end

   typedef struct {int cyc; int kind; logic wr; logic [AW-1:0] addr; logic [DW-1:0] wd;} acc_t;
   typedef struct {int cyc; logic [DW-1:0] data;} rv_t;
   typedef struct {int cyc; logic [2:0] v;} st_t;   // {busy, rvalid, ack}

   acc_t acc_q[$];
   rv_t  rv_q[$];
   int   ack_q[$];
   st_t  st_q[$];

   int total  = 0;
   int passed = 0;
   logic drain = 1'b0;

   task automatic push_acc(int c, int k, logic wr, logic [AW-1:0] ad, logic [DW-1:0] wd);
      acc_t a;
      a.cyc = c; a.kind = k; a.wr = wr; a.addr = ad; a.wd = wd;
      acc_q.push_back(a);
   endtask

   task automatic push_rv(int c, logic [DW-1:0] d);
      rv_t r;
      r.cyc = c; r.data = d;
      rv_q.push_back(r);
   endtask

   task automatic push_st(int c, logic [2:0] v);
      st_t s;
      s.cyc = c; s.v = v;
      st_q.push_back(s);
   endtask

   task automatic push_sweep(int start, int n, bit with_ack);
      for (int i = 0; i < n; i++) push_acc(start + i, 0, 1'b1, AW'(i), 7'h00);
      if (with_ack) ack_q.push_back(start + n);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(int c);
      while (cyc < c) tick();
   endtask

   // Monitor: all comparisons and counters live in this one process.
   initial begin : monitor
      acc_t a;
      rv_t  r;
      st_t  s;
      int   e;
      bit   drained;
      drained = 1'b0;
      forever begin
         @(negedge clk);
         while (st_q.size() > 0 && st_q[0].cyc < cyc) begin
            total++;
            $display("FAIL status_missing: expected at cycle %0d, none taken by cycle %0d", st_q[0].cyc, cyc);
            void'(st_q.pop_front());
         end
         if (st_q.size() > 0 && st_q[0].cyc == cyc) begin
            s = st_q.pop_front();
            total++;
            if ({busy_o, lookup_rvalid_o, flush_ack_o} === s.v) passed++;
            else $display("FAIL status: got %b required %b (busy,rvalid,ack) cycle %0d",
                          {busy_o, lookup_rvalid_o, flush_ack_o}, s.v, cyc);
         end
         if (rst_n === 1'b1) begin
            while (acc_q.size() > 0 && acc_q[0].cyc < cyc) begin
               total++;
               $display("FAIL access_missing: required access at cycle %0d, none by cycle %0d", acc_q[0].cyc, cyc);
               void'(acc_q.pop_front());
            end
            if (tag_req_o) begin
               if (acc_q.size() > 0 && acc_q[0].cyc == cyc) begin
                  a = acc_q.pop_front();
                  total++;
                  if ({tag_write_o, tag_addr_o, tag_wdata_o, refill_gnt_o, lookup_gnt_o} ===
                      {a.wr, a.addr, a.wd, (a.kind == 1), (a.kind == 2)}) passed++;
                  else $display("FAIL access: got wr=%b addr=%0d wdata=%h rgnt=%b lgnt=%b required wr=%b addr=%0d wdata=%h kind=%0d cycle %0d",
                                tag_write_o, tag_addr_o, tag_wdata_o, refill_gnt_o, lookup_gnt_o,
                                a.wr, a.addr, a.wd, a.kind, cyc);
               end else begin
                  total++;
                  $display("FAIL unexpected_access: got addr=%0d wr=%b at cycle %0d, required no access",
                           tag_addr_o, tag_write_o, cyc);
               end
            end else begin
               total++;
               if ({tag_write_o, tag_addr_o, tag_wdata_o, refill_gnt_o, lookup_gnt_o} === 16'h0000) passed++;
               else $display("FAIL idle_pins: got wr=%b addr=%0d wdata=%h rgnt=%b lgnt=%b required all 0 cycle %0d",
                             tag_write_o, tag_addr_o, tag_wdata_o, refill_gnt_o, lookup_gnt_o, cyc);
            end
            while (rv_q.size() > 0 && rv_q[0].cyc < cyc) begin
               total++;
               $display("FAIL rvalid_missing: required at cycle %0d, none by cycle %0d", rv_q[0].cyc, cyc);
               void'(rv_q.pop_front());
            end
            if (lookup_rvalid_o) begin
               if (rv_q.size() > 0 && rv_q[0].cyc == cyc) begin
                  r = rv_q.pop_front();
                  total++;
                  if (rdata === r.data) passed++;
                  else $display("FAIL rdata: got %h required %h cycle %0d", rdata, r.data, cyc);
               end else begin
                  total++;
                  $display("FAIL unexpected_rvalid: got rvalid at cycle %0d, required none", cyc);
               end
            end
            if (flush_ack_o) begin
               if (ack_q.size() > 0) begin
                  e = ack_q.pop_front();
                  total++;
                  if (cyc == e) passed++;
                  else $display("FAIL flush_ack_cycle: got %0d required %0d", cyc, e);
               end else begin
                  total++;
                  $display("FAIL unexpected_ack: got ack at cycle %0d, required none", cyc);
               end
            end else if (ack_q.size() > 0 && ack_q[0] < cyc) begin
               total++;
               $display("FAIL ack_missing: required at cycle %0d, none by cycle %0d", ack_q[0], cyc);
               void'(ack_q.pop_front());
            end
         end
         if (drain && !drained) begin
            drained = 1'b1;
            total++;
            e = acc_q.size() + rv_q.size() + ack_q.size() + st_q.size();
            if (e == 0) passed++;
            else $display("FAIL queues_empty: got %0d outstanding entries required 0", e);
         end
      end
   end

   // Directed stimulus.
   initial begin : stim
      int t;
      rst_n = 1'b0; flush_req_i = 1'b0;
      lookup_req_i = 1'b0; lookup_addr_i = 6'd0;
      refill_req_i = 1'b0; refill_addr_i = 6'd0; refill_wdata_i = 7'h00;
      repeat (3) tick();

      // Reset state, then release.
      t = cyc;
      push_st(t, {BUSY_RST, 1'b0, 1'b0});
      rst_n = 1'b1;
`ifdef TAG_FLUSH_ON_RESET_EN
      push_sweep(t + 1, N, 1'b1);
      push_st(t + 65, 3'b101);
      push_st(t + 66, 3'b000);
      wait_until(t + 66);
      tick();
`else
      refill_req_i = 1'b1; refill_addr_i = 6'd63; refill_wdata_i = 7'h7f;
      push_acc(t, 1, 1'b1, 6'd63, 7'h7f);
      tick();
      refill_req_i = 1'b0;
      t = cyc;
      flush_req_i = 1'b1;
      push_sweep(t + 1, N, 1'b1);
      push_st(t + 65, 3'b101);
      push_st(t + 66, 3'b000);
      tick();
      flush_req_i = 1'b0;
      wait_until(t + 66);
      tick();
`endif

      // Refill and lookup together: refill first, lookup next cycle.
      t = cyc;
      refill_req_i = 1'b1; refill_addr_i = 6'd5; refill_wdata_i = 7'h45;
      lookup_req_i = 1'b1; lookup_addr_i = 6'd9;
      push_acc(t, 1, 1'b1, 6'd5, 7'h45);
      push_acc(t + 1, 2, 1'b0, 6'd9, 7'h00);
      push_rv(t + 2, 7'h00);
      tick();
      refill_req_i = 1'b0;
      tick();
      lookup_req_i = 1'b0;

      // Two refills, then back-to-back lookups 1,2,3 and 5.
      t = cyc;
      refill_req_i = 1'b1; refill_addr_i = 6'd1; refill_wdata_i = 7'h11;
      push_acc(t, 1, 1'b1, 6'd1, 7'h11);
      tick();
      refill_addr_i = 6'd2; refill_wdata_i = 7'h2a;
      push_acc(t + 1, 1, 1'b1, 6'd2, 7'h2a);
      tick();
      refill_req_i = 1'b0;
      lookup_req_i = 1'b1;
      lookup_addr_i = 6'd1; push_acc(t + 2, 2, 1'b0, 6'd1, 7'h00); push_rv(t + 3, 7'h11); tick();
      lookup_addr_i = 6'd2; push_acc(t + 3, 2, 1'b0, 6'd2, 7'h00); push_rv(t + 4, 7'h2a); tick();
      lookup_addr_i = 6'd3; push_acc(t + 4, 2, 1'b0, 6'd3, 7'h00); push_rv(t + 5, 7'h00); tick();
      lookup_addr_i = 6'd5; push_acc(t + 5, 2, 1'b0, 6'd5, 7'h00); push_rv(t + 6, 7'h45); tick();
      lookup_req_i = 1'b0;
      tick();

      // Flush re-requested at entry 30: two full sweeps, lookup held across the gap.
      t = cyc;
      flush_req_i = 1'b1;
      push_sweep(t + 1, N, 1'b1);
      push_st(t + 65, 3'b101);
      push_st(t + 66, 3'b100);
      push_st(t + 131, 3'b101);
      push_st(t + 132, 3'b000);
      tick();
      flush_req_i = 1'b0;
      wait_until(t + 31);
      flush_req_i = 1'b1;
      tick();
      flush_req_i = 1'b0;
      push_sweep(t + 67, N, 1'b1);
      wait_until(t + 60);
      lookup_req_i = 1'b1; lookup_addr_i = 6'd4;
      push_acc(t + 132, 2, 1'b0, 6'd4, 7'h00);
      push_rv(t + 133, 7'h00);
      wait_until(t + 133);
      lookup_req_i = 1'b0;
      tick();

      // Lookup raised together with a flush: stalls through FLUSH and DONE.
      t = cyc;
      flush_req_i = 1'b1;
      lookup_req_i = 1'b1; lookup_addr_i = 6'd7;
      push_sweep(t + 1, N, 1'b1);
      push_st(t + 65, 3'b101);
      push_acc(t + 66, 2, 1'b0, 6'd7, 7'h00);
      push_rv(t + 67, 7'h00);
      tick();
      flush_req_i = 1'b0;
      wait_until(t + 67);
      lookup_req_i = 1'b0;
      tick();

      // Reset for one cycle at sweep entry 40: no ack for the aborted sweep.
      t = cyc;
      flush_req_i = 1'b1;
      push_sweep(t + 1, 40, 1'b0);
      tick();
      flush_req_i = 1'b0;
      wait_until(t + 41);
      rst_n = 1'b0;
      tick();
      push_st(t + 42, {BUSY_RST, 1'b0, 1'b0});
      rst_n = 1'b1;
`ifdef TAG_FLUSH_ON_RESET_EN
      push_sweep(t + 43, N, 1'b1);
      push_st(t + 107, 3'b101);
      push_st(t + 108, 3'b000);
      wait_until(t + 108);
`else
      lookup_req_i = 1'b1; lookup_addr_i = 6'd45;
      push_acc(t + 42, 2, 1'b0, 6'd45, 7'h00);
      push_rv(t + 43, 7'h00);
      tick();
      lookup_req_i = 1'b0;
`endif

      repeat (4) tick();
      drain = 1'b1;
      repeat (2) tick();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
